// File: rtl/ysyx_22050078_mdu.sv
// ysyx_22050078_mdu: iterative RV64M mul/div unit; ports: clk, rst_n, i_valid/o_ready + i_opt/i_src1/i_src2 request, i_flush abort, o_valid/i_ready + o_res result, o_busy
module ysyx_22050078_mdu #(
  parameter int XLEN = 64,
  parameter int OPT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [OPT_WIDTH-1:0] i_opt,
  input  logic [XLEN-1:0]      i_src1,
  input  logic [XLEN-1:0]      i_src2,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_res,
  output logic                 o_busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int WSH = XLEN - 32;
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] wext(input logic w, input logic [XLEN-1:0] x);
    return w ? XLEN'($signed(x[31:0])) : x;
  endfunction

  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN-1:0] opa, opb, q, r, res_raw;
  logic [XLEN:0] diff;
  logic mul_r, high_r, rem_r, w_r, neg_q, neg_r;
  logic [31:0] opn;
  logic legal, d_w, d_mul, d_high, d_rem, d_sgn, s1, s2, n1, n2, div0, ovf, fast;
  logic [XLEN-1:0] e1, e2, m1, m2, fast_res;

  assign opn = 32'(i_opt);
  assign legal = opn <= 7 || (XLEN == 64 && opn <= 12);
  assign d_w = legal && opn >= 8;
  assign d_mul = legal && (opn <= 3 || opn == 8);
  assign d_high = opn >= 1 && opn <= 3;
  assign d_rem = opn == 6 || opn == 7 || opn == 11 || opn == 12;
  assign d_sgn = opn == 4 || opn == 6 || opn == 9 || opn == 11;
  assign s1 = d_mul ? (opn == 1 || opn == 2) : d_sgn;
  assign s2 = d_mul ? opn == 1 : d_sgn;
  assign e1 = d_w ? (s1 ? XLEN'($signed(i_src1[31:0])) : XLEN'(i_src1[31:0])) : i_src1;
  assign e2 = d_w ? (s2 ? XLEN'($signed(i_src2[31:0])) : XLEN'(i_src2[31:0])) : i_src2;
  assign n1 = s1 & e1[XLEN-1];
  assign n2 = s2 & e2[XLEN-1];
  assign m1 = n1 ? -e1 : e1;
  assign m2 = n2 ? -e2 : e2;
  assign div0 = legal && !d_mul && e2 == '0;
  assign ovf = legal && !d_mul && d_sgn && e2 == '1 && (d_w ? e1[31:0] == 32'h8000_0000 : e1 == MIN);
  assign fast = !legal || div0 || ovf;
  assign fast_res = !legal ? '0 : wext(d_w, div0 ? (d_rem ? e1 : '1) : (d_rem ? '0 : e1));

  // W operands sit in the top half so 32 steps consume exactly their bits
  assign diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opa};
  assign acc_step = mul_r ? (acc << 1) + (opb[XLEN-1] ? {{XLEN{1'b0}}, opa} : '0)
                  : diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign prod = neg_q ? -acc_step : acc_step;
  assign q = acc_step[XLEN-1:0];
  assign r = acc_step[2*XLEN-1:XLEN];
  assign res_raw = mul_r ? (high_r ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0])
                 : rem_r ? (neg_r ? -r : r) : (neg_q ? -q : q);

  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  assign o_busy = state != IDLE;

  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      o_res <= '0;
      acc <= '0;
      opa <= '0;
      opb <= '0;
      {mul_r, high_r, rem_r, w_r, neg_q, neg_r} <= '0;
    end else if (i_flush) begin
      state <= IDLE;
      cnt <= '0;
    end else
      case (state)
        IDLE: if (i_valid) begin
          {mul_r, high_r, rem_r, w_r, neg_q, neg_r} <= {d_mul, d_high, d_rem, d_w, n1 ^ n2, n1};
          opa <= d_mul ? m1 : m2;
          opb <= d_w ? m2 << WSH : m2;
          acc <= d_mul ? '0 : {{XLEN{1'b0}}, d_w ? m1 << WSH : m1};
          cnt <= fast ? '0 : d_w ? CW'(32) : CW'(XLEN);
          state <= fast ? DONE : CALC;
          if (fast) o_res <= fast_res;
        end
        CALC: begin
          acc <= acc_step;
          opb <= opb << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            o_res <= wext(w_r, res_raw);
          end
        end
        DONE: if (i_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ysyx_22050078_mdu.sv
// tb_ysyx_22050078_mdu: directed vectors, corner sequences and random ops against an arithmetic model
module tb_ysyx_22050078_mdu;
  logic clk = 0, rst_n = 0, i_valid = 0, i_flush = 0, i_ready = 0;
  logic o_ready, o_valid, o_busy;
  logic [3:0] i_opt = 0;
  logic [63:0] i_src1 = 0, i_src2 = 0, o_res;
  int checks = 0, errors = 0;

  ysyx_22050078_mdu #(.XLEN(64), .OPT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_opt(i_opt),
    .i_src1(i_src1), .i_src2(i_src2), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_res(o_res), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    logic [63:0] a, b, res;
    int lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input int op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    logic signed [63:0] sq;
    logic signed [31:0] a32, b32, q32;
    logic [31:0] r;
    logic [63:0] res;
    logic ovf, ovw;
    sa = $signed(a);
    sb = $signed(b);
    ua = {64'd0, a};
    ub = {64'd0, b};
    a32 = a[31:0];
    b32 = b[31:0];
    ovf = a == 64'h8000_0000_0000_0000 && b == '1;
    ovw = a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    res = 0;
    r = 0;
    case (op)
      0: res = a * b;
      1: begin p = sa * sb; res = p[127:64]; end
      2: begin p = sa * ub; res = p[127:64]; end
      3: begin p = ua * ub; res = p[127:64]; end
      4: if (b == 0) res = '1; else if (ovf) res = a; else begin sq = $signed(a) / $signed(b); res = sq; end
      5: if (b == 0) res = '1; else res = a / b;
      6: if (b == 0) res = a; else if (ovf) res = 0; else begin sq = $signed(a) % $signed(b); res = sq; end
      7: if (b == 0) res = a; else res = a % b;
      8: r = a[31:0] * b[31:0];
      9: if (b32 == 0) r = '1; else if (ovw) r = a[31:0]; else begin q32 = a32 / b32; r = q32; end
      10: if (b32 == 0) r = '1; else r = a[31:0] / b[31:0];
      11: if (b32 == 0) r = a[31:0]; else if (ovw) r = 0; else begin q32 = a32 % b32; r = q32; end
      12: if (b32 == 0) r = a[31:0]; else r = a[31:0] % b[31:0];
      default: res = 0;
    endcase
    if (op >= 8 && op <= 12) res = 64'($signed(r));
    return res;
  endfunction

  function automatic int ref_lat(input int op, input logic [63:0] a, input logic [63:0] b);
    logic w;
    logic [63:0] ea, eb;
    w = op >= 8;
    ea = w ? 64'($signed(a[31:0])) : a;
    eb = w ? 64'($signed(b[31:0])) : b;
    if (op > 12) return 1;
    if (op inside {4, 5, 6, 7, 9, 10, 11, 12}) begin
      if (eb == 0) return 1;
      if (op inside {4, 6, 9, 11} && eb == '1 && ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
    end
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      5: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // latency counts the accept cycle as 0, so fast-path results arrive at 1
  task automatic run(input string name, input int op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int lat);
    int n = 0, g = 0;
    while (!o_ready && g < 200) begin @(posedge clk); #1; g++; end
    i_valid = 1;
    i_opt = 4'(op);
    i_src1 = a;
    i_src2 = b;
    @(posedge clk); #1;
    i_valid = 0;
    i_opt = 4'($urandom);
    i_src1 = {$urandom, $urandom};
    i_src2 = {$urandom, $urandom};
    while (!o_valid && n < 200) begin @(posedge clk); #1; n++; end
    check($sformatf("%s res", name), o_res, exp);
    check($sformatf("%s lat", name), 64'(n + 1), 64'(lat));
    i_ready = 1;
    @(posedge clk); #1;
    i_ready = 0;
    check($sformatf("%s ack", name), 64'({o_valid, o_ready}), 64'(2'b01));
  endtask

  vec_t v[14];

  initial begin
    int nv;
    v[0]  = '{0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    v[1]  = '{4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    v[2]  = '{6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    v[3]  = '{5,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[4]  = '{7,  64'd5, 64'd0, 64'd5, 1};
    v[5]  = '{4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    v[6]  = '{6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    v[7]  = '{3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    v[8]  = '{10, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    v[9]  = '{13, 64'd9, 64'd3, 64'd0, 1};
    v[10] = '{8,  64'd3, 64'h7FFF_FFFF, 64'h7FFF_FFFD, 33};
    v[11] = '{12, 64'hFFFF_FFFF, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[12] = '{9,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    v[13] = '{1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
    repeat (2) @(posedge clk);
    #1;
    check("reset ready/valid/busy", 64'({o_ready, o_valid, o_busy}), 64'(3'b100));
    check("reset res", o_res, 64'd0);
    rst_n = 1;
    for (int i = 0; i < 14; i++) run($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].res, v[i].lat);
    // flush mid-calculation
    i_valid = 1; i_opt = 0; i_src1 = 64'd11; i_src2 = 64'd13;
    @(posedge clk); #1;
    i_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    i_flush = 1;
    @(posedge clk); #1;
    i_flush = 0;
    check("flush busy/ready/valid", 64'({o_busy, o_ready, o_valid}), 64'(3'b010));
    nv = 0;
    repeat (80) begin @(posedge clk); #1; nv += int'(o_valid); end
    check("flush no valid", 64'(nv), 64'd0);
    // result held while consumer stalls
    i_valid = 1; i_opt = 4; i_src1 = 64'd100; i_src2 = 64'd7;
    @(posedge clk); #1;
    i_valid = 0;
    nv = 0;
    while (!o_valid && nv < 200) begin @(posedge clk); #1; nv++; end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold valid %0d", k), 64'(o_valid), 64'd1);
      check($sformatf("hold res %0d", k), o_res, 64'd14);
      @(posedge clk); #1;
    end
    i_ready = 1;
    @(posedge clk); #1;
    i_ready = 0;
    nv = 0;
    repeat (10) begin nv += int'(o_valid); @(posedge clk); #1; end
    check("hold single completion", 64'(nv), 64'd0);
    // reset discards an in-flight op
    i_valid = 1; i_opt = 4'd5; i_src1 = 64'd50; i_src2 = 64'd3;
    @(posedge clk); #1;
    i_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("mid reset busy/valid", 64'({o_busy, o_valid}), 64'(2'b00));
    check("mid reset res", o_res, 64'd0);
    for (int t = 0; t < 60; t++) begin
      int op;
      logic [63:0] a, b;
      op = $urandom_range(0, 15);
      a = pick();
      b = pick();
      run($sformatf("rnd%0d op%0d", t, op), op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050078_mdu.md
YSYX_22050078_MDU -- requirements
Module: ysyx_22050078_mdu

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand and result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter OPT_WIDTH, default 4, giving the width of the operation select.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_valid, input, 1 bit: request valid.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port i_opt, input, OPT_WIDTH bits: the operation select; encoding is in REQ-014.
REQ-008 The block SHALL have ports i_src1 and i_src2, inputs, XLEN bits each: the operands.
REQ-009 The block SHALL have port i_flush, input, 1 bit: abort any in-flight operation.
REQ-010 The block SHALL have port o_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port i_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port o_res, output, XLEN bits: the result.
REQ-013 The block SHALL have port o_busy, output, 1 bit: the block is in any state other than IDLE.

Function
REQ-014 Opcode encoding SHALL be: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; codes 13-15 are illegal, and codes 8-12 are also illegal when XLEN=32.
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-016 A request SHALL be accepted on a clock edge where i_valid && o_ready; the operands and opcode are registered at that edge, and later input changes have no effect.
REQ-017 On acceptance of a normal operation, the FSM SHALL go IDLE->CALC and load the iteration counter with N (N=XLEN for full-width ops, N=32 for W ops).
REQ-018 In CALC, the block SHALL perform one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes) and decrement the counter; at count 0 it goes to DONE; o_valid therefore rises N+1 cycles after the accept edge.
REQ-019 The fast path SHALL go IDLE->DONE directly, with o_valid one cycle after acceptance, for: illegal opcodes (o_res=0); divide by zero (quotient all ones, remainder = dividend); signed overflow MIN/-1 (quotient = MIN, remainder = 0).
REQ-020 Signed operands SHALL be converted to magnitudes before iteration; the final sign SHALL be applied as follows: product sign = sign1^sign2; quotient sign = sign1^sign2; remainder sign = sign of the dividend.
REQ-021 Signedness per op SHALL be: MULH both signed; MULHSU src1 signed, src2 unsigned; MULHU, DIVU, REMU, DIVUW, REMUW unsigned; DIV, REM, DIVW, REMW signed.
REQ-022 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-023 W ops SHALL use src[31:0] only, and their 32-bit result SHALL be sign-extended to 64 bits, including DIVUW and REMUW.
REQ-024 In DONE, o_res and o_valid SHALL hold stable until i_ready=1; on that edge the FSM returns to IDLE; there is no acceptance in the same cycle (o_ready=0 in DONE).
REQ-025 i_flush=1 in any state SHALL force IDLE on the next edge, with no o_valid for the aborted op; i_flush has priority over acceptance and over the DONE handshake.
REQ-026 A 32-bit result mapped into a 64-bit register SHALL equal the corresponding operation on 64-bit values for W ops, matching the RV64M specification.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL set: state=IDLE, counter=0, o_valid=0, o_ready=1 after the edge, o_res=0, o_busy=0.
REQ-028 Reset asserted during CALC or DONE SHALL discard the operation, with no o_valid on the next cycle; reset has priority over i_flush and over handshakes.

Verification
REQ-029 The bench SHALL check: MUL src1=7, src2=-3 (XLEN=64) -> o_res=0xFFFF_FFFF_FFFF_FFEB, with o_valid exactly 65 cycles after the accept edge.
REQ-030 The bench SHALL check: DIV src1=-7, src2=2 -> o_res=0xFFFF_FFFF_FFFF_FFFD; REM on the same operands -> o_res=0xFFFF_FFFF_FFFF_FFFF.
REQ-031 The bench SHALL check: DIVU src1=5, src2=0 -> o_res=all ones, with o_valid one cycle after acceptance; REMU on the same operands -> o_res=5.
REQ-032 The bench SHALL check: DIV src1=0x8000_0000_0000_0000, src2=-1 -> o_res=0x8000_0000_0000_0000; REM on the same operands -> o_res=0; both via the fast path.
REQ-033 The bench SHALL check: MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> o_res=0xFFFF_FFFF_FFFF_FFFE; DIVUW src1=0xFFFF_FFFF, src2=1 -> o_res=0xFFFF_FFFF_FFFF_FFFF after 33 cycles.
REQ-034 The bench SHALL check: i_flush pulsed at CALC cycle 10 -> o_busy=0 and o_ready=1 on the next cycle, with no o_valid; i_ready held at 0 for 5 cycles in DONE -> o_res stable throughout, with a single completion.
